// File: rtl/lsu_mem.sv
// rtl/lsu_mem.sv - RV32 load/store memory stage; LSU_MISALIGNED_SPLIT_EN builds the two-beat misaligned path
module lsu_mem #(
    parameter int DEPTH_WORDS = 256,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err
);
    localparam int IW = $clog2(DEPTH_WORDS);

`ifdef LSU_MISALIGNED_SPLIT_EN
    typedef enum logic [1:0] {S_IDLE, S_RESP, S_SPLIT} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_RESP} state_t;
`endif

    state_t       state_q, state_d;
    logic [31:0]  mem_q [DEPTH_WORDS];
    logic [31:0]  rdata_q, rdata_d;
    logic         err_q, err_d;

    logic [IW-1:0] idx;
    logic [1:0]    off;
    logic [1:0]    size_m1;
    logic [3:0]    size_mask;
    logic [7:0]    be_all;
    logic [31:0]   wsh_lo, wsh_hi;
    logic          legal, misal, accept, err_acc, split_go, first_beat;
    logic          unused_addr;

    function automatic logic [31:0] load_ext(input logic [31:0] raw, input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return f3[2] ? {24'b0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
            2'b01:   return f3[2] ? {16'b0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
            default: return raw;
        endcase
    endfunction

    assign idx         = req_addr[IW+1:2];
    assign off         = req_addr[1:0];
    assign unused_addr = ^req_addr[ADDR_WIDTH-1:IW+2];

    always_comb begin
        size_m1   = 2'd3;
        size_mask = 4'b1111;
        case (req_funct3[1:0])
            2'b00: begin size_m1 = 2'd0; size_mask = 4'b0001; end
            2'b01: begin size_m1 = 2'd1; size_mask = 4'b0011; end
            default: ;
        endcase
    end

    assign legal = req_write ? (req_funct3 == 3'b000 || req_funct3 == 3'b001 || req_funct3 == 3'b010)
                             : !(req_funct3 == 3'b011 || req_funct3 == 3'b110 || req_funct3 == 3'b111);
    assign misal = ({1'b0, off} + {1'b0, size_m1}) > 3'd3;
    // Byte lanes and data span two words; the upper half feeds the second beat.
    assign be_all           = {4'b0, size_mask} << off;
    assign {wsh_hi, wsh_lo} = {32'b0, req_wdata} << {off, 3'b000};

    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign accept    = req_valid && req_ready;

`ifdef LSU_MISALIGNED_SPLIT_EN
    logic [IW-1:0] idx_q, idx_nx;
    logic [1:0]    off_q;
    logic [2:0]    f3_q;
    logic          write_q;
    logic [31:0]   wdata_hi_q, w0_q, split_raw, unused_pair;
    logic [3:0]    be_hi_q;

    assign split_go = legal && misal;
    assign err_acc  = !legal;
    assign idx_nx   = idx_q + 1'b1;
    assign {unused_pair, split_raw} = {mem_q[idx_nx], w0_q} >> {off_q, 3'b000};

    always_ff @(posedge clk) begin
        if (accept) begin
            idx_q      <= idx;
            off_q      <= off;
            f3_q       <= req_funct3;
            write_q    <= req_write;
            wdata_hi_q <= wsh_hi;
            be_hi_q    <= be_all[7:4];
            w0_q       <= mem_q[idx];
        end
    end
`else
    logic unused_split;
    assign split_go     = 1'b0;
    assign err_acc      = !legal || misal;
    assign unused_split = ^{wsh_hi, be_all[7:4]};
`endif

    assign first_beat = accept && !err_acc && !rst;

    // Array is deliberately not reset; a split store's first beat survives reset.
    always_ff @(posedge clk) begin
        if (first_beat && req_write) begin
            for (int b = 0; b < 4; b++) begin
                if (be_all[b]) mem_q[idx][b*8 +: 8] <= wsh_lo[b*8 +: 8];
            end
        end
`ifdef LSU_MISALIGNED_SPLIT_EN
        if (state_q == S_SPLIT && write_q && !rst) begin
            for (int b = 0; b < 4; b++) begin
                if (be_hi_q[b]) mem_q[idx_nx][b*8 +: 8] <= wdata_hi_q[b*8 +: 8];
            end
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (split_go) begin
                        state_d = state_t'(2'd2);
                    end else begin
                        state_d = S_RESP;
                        err_d   = err_acc;
                        rdata_d = (err_acc || req_write) ? 32'b0
                                : load_ext(mem_q[idx] >> {off, 3'b000}, req_funct3);
                    end
                end
            end
`ifdef LSU_MISALIGNED_SPLIT_EN
            S_SPLIT: begin
                state_d = S_RESP;
                err_d   = 1'b0;
                rdata_d = write_q ? 32'b0 : load_ext(split_raw, f3_q);
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            rdata_q <= 32'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_lsu_mem.sv
// tb/tb_lsu_mem.sv - randomized self-checking bench for lsu_mem against a byte-array reference model
module tb_lsu_mem;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int n_cmp = 0;
    int n_fail = 0;
    logic [7:0] mb [1024];

`ifdef LSU_MISALIGNED_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    lsu_mem #(.DEPTH_WORDS(256), .ADDR_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_funct3(req_funct3), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    task automatic model_op(input logic w, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wd, output logic [31:0] exp_rd,
                            output logic exp_err, output int exp_lat);
        int size;
        int a;
        logic legal, mis;
        logic [31:0] v;
        size  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        legal = w ? (f3 <= 3'd2) : !(f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
        mis   = (int'(addr[1:0]) + size) > 4;
        a     = int'(addr[9:0]);
        exp_err = !legal || (mis && !SPLIT_EN);
        exp_lat = (!exp_err && mis) ? 2 : 1;
        exp_rd  = 32'b0;
        if (!exp_err) begin
            if (w) begin
                for (int i = 0; i < size; i++) mb[(a + i) % 1024] = wd[i*8 +: 8];
            end else begin
                v = 32'b0;
                for (int i = 0; i < size; i++) v = v | (32'(mb[(a + i) % 1024]) << (8 * i));
                if (!f3[2] && size == 1 && v[7])  v = v | 32'hFFFF_FF00;
                if (!f3[2] && size == 2 && v[15]) v = v | 32'hFFFF_0000;
                exp_rd = v;
            end
        end
    endtask

    task automatic issue(input logic w, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, output logic [31:0] rd, output logic er,
                         output int lat);
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_idle: got %b want 1", req_ready);
        end
        req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                lat = c;
                break;
            end
        end
        rd = rsp_rdata;
        er = rsp_err;
        n_cmp++;
        if (lat == 0 || req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rsp_seen: lat %0d ready %b want rsp with ready 0", lat, req_ready);
        end
    endtask

    task automatic do_op(input logic w, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, output logic [31:0] rd);
        logic [31:0] exp_rd;
        logic exp_err, er;
        int exp_lat, lat;
        model_op(w, f3, addr, wd, exp_rd, exp_err, exp_lat);
        issue(w, f3, addr, wd, rd, er, lat);
        n_cmp++;
        if (rd !== exp_rd || er !== exp_err || lat != exp_lat) begin
            n_fail++;
            $display("FAIL op w=%0d f3=%0d addr=%h: got rd %h err %b lat %0d want rd %h err %b lat %0d",
                     w, f3, addr, rd, er, lat, exp_rd, exp_err, exp_lat);
        end
    endtask

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'b0;
        req_addr = 32'b0; req_wdata = 32'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_val("reset_state", {28'b0, req_ready, rsp_valid, rsp_err, 1'b0}, 32'h8);
        check_val("reset_rdata", rsp_rdata, 32'h0);
    endtask

    task automatic test_fill();
        logic [31:0] rd;
        for (int i = 0; i < 256; i++) do_op(1'b1, 3'b010, 32'(i * 4), $urandom, rd);
    endtask

    task automatic test_basic();
        logic [31:0] rd;
        do_op(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, rd);
        do_op(1'b0, 3'b010, 32'h10, 32'h0, rd);
        check_val("lw_deadbeef", rd, 32'hDEAD_BEEF);
        do_op(1'b1, 3'b010, 32'h10, 32'h1122_3344, rd);
        do_op(1'b1, 3'b000, 32'h13, 32'h0000_0080, rd);
        do_op(1'b0, 3'b000, 32'h13, 32'h0, rd);
        check_val("lb_sext", rd, 32'hFFFF_FF80);
        do_op(1'b0, 3'b100, 32'h13, 32'h0, rd);
        check_val("lbu_zext", rd, 32'h0000_0080);
        do_op(1'b0, 3'b010, 32'h10, 32'h0, rd);
        check_val("lw_after_sb", rd, 32'h8022_3344);
        do_op(1'b0, 3'b101, 32'hFFFF_FC12, 32'h0, rd);
        check_val("lhu_wrap_addr", rd, 32'h0000_8022);
    endtask

    task automatic test_misaligned();
        logic [31:0] rd;
        logic er;
        int lat;
`ifdef LSU_MISALIGNED_SPLIT_EN
        do_op(1'b1, 3'b010, 32'h3FE, 32'hAABB_CCDD, rd);
        do_op(1'b0, 3'b010, 32'h3FE, 32'h0, rd);
        check_val("lw_split_wrap", rd, 32'hAABB_CCDD);
        do_op(1'b0, 3'b001, 32'h0, 32'h0, rd);
        check_val("lh_after_split", rd, 32'hFFFF_AABB);
`else
        do_op(1'b1, 3'b010, 32'h0, 32'h5566_7788, rd);
        model_op(1'b0, 3'b010, 32'h1, 32'h0, rd, er, lat);
        issue(1'b0, 3'b010, 32'h1, 32'h0, rd, er, lat);
        check_val("misal_err", {rd[30:0], er}, 32'h1);
        check_val("misal_lat", 32'(lat), 32'd1);
        do_op(1'b1, 3'b001, 32'h3, 32'hFFFF, rd);
        do_op(1'b0, 3'b010, 32'h0, 32'h0, rd);
        check_val("misal_no_write", rd, 32'h5566_7788);
`endif
    endtask

    task automatic test_illegal();
        logic [31:0] rd;
        do_op(1'b1, 3'b010, 32'h20, 32'h0BAD_F00D, rd);
        do_op(1'b0, 3'b011, 32'h20, 32'h0, rd);
        do_op(1'b1, 3'b100, 32'h20, 32'hFFFF_FFFF, rd);
        do_op(1'b0, 3'b010, 32'h20, 32'h0, rd);
        check_val("illegal_no_write", rd, 32'h0BAD_F00D);
    endtask

    task automatic test_random();
        logic [31:0] rd, addr;
        for (int i = 0; i < 300; i++) begin
            addr = ($urandom & 32'hFFFF_FC00) |
                   (($urandom % 2 == 0) ? $urandom_range(0, 63) : $urandom_range(32'h3C0, 32'h3FF));
            do_op(1'($urandom % 2), 3'($urandom % 8), addr, $urandom, rd);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd, exp_rd;
        logic exp_err;
        int exp_lat;
        do_op(1'b0, 3'b010, 32'h10, 32'h0, rd);
        @(negedge clk);
`ifdef LSU_MISALIGNED_SPLIT_EN
        mb[32'h0FE] = 8'h0D; mb[32'h0FF] = 8'hF0;
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h0FE; req_wdata = 32'hCAFE_F00D;
`else
        model_op(1'b1, 3'b010, 32'h0F8, 32'hCAFE_F00D, exp_rd, exp_err, exp_lat);
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h0F8; req_wdata = 32'hCAFE_F00D;
`endif
        @(posedge clk);
        #1 req_valid = 1'b0; rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_val("rst_mid_state", {29'b0, req_ready, rsp_valid, rsp_err}, 32'h4);
        check_val("rst_mid_rdata", rsp_rdata, 32'h0);
        @(negedge clk);
        check_val("rst_mid_no_rsp", {31'b0, rsp_valid}, 32'h0);
        do_op(1'b0, 3'b010, 32'h0FC, 32'h0, rd);
        do_op(1'b0, 3'b010, 32'h100, 32'h0, rd);
`ifdef LSU_MISALIGNED_SPLIT_EN
        do_op(1'b0, 3'b101, 32'h0FE, 32'h0, rd);
        check_val("rst_first_beat", rd, 32'h0000_F00D);
`else
        do_op(1'b0, 3'b010, 32'h0F8, 32'h0, rd);
        check_val("rst_store_kept", rd, 32'hCAFE_F00D);
`endif
    endtask

    initial begin
        test_reset();
        test_fill();
        test_basic();
        test_misaligned();
        test_illegal();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
